// File: rtl/sram_pkg.sv
// Shared defaults and controller state encoding for the 1RW/1R SRAM wrapper.
package sram_pkg;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_LANE_WIDTH     = 8;
  localparam int DEF_OUT_REG        = 0;
  localparam int DEF_CLEAR_ON_RESET = 1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_t;
endpackage

// File: rtl/sram_out_stage.sv
// Optional output register slice: data holds its last loaded value, valid tracks the input.
module sram_out_stage
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  vin,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vout
);

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      dout <= '0;
      vout <= 1'b0;
    end else begin
      vout <= vin;
      if (vin) dout <= din;
    end
  end

endmodule

// File: rtl/sram_1rw1r_param.sv
// One read/write port plus one read-only port SRAM with lane write masks,
// write-first port-1 bypass on address collision, and optional zero-fill after reset.
//
// state    | meaning
// ST_INIT  | zero-filling one word per cycle, requests ignored
// ST_READY | normal read/write service
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int  DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int  LANE_WIDTH     = DEF_LANE_WIDTH,
  parameter int  OUT_REG        = DEF_OUT_REG,
  parameter int  CLEAR_ON_RESET = DEF_CLEAR_ON_RESET,
  localparam int RAM_DEPTH      = 2 ** ADDR_WIDTH,
  localparam int NUM_WMASKS     = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_busy,
  output logic                  collision
);

  sram_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  wr_en, rd0_en, rd1_en, hit;
  logic [DATA_WIDTH-1:0] rd1_word, q0, q1;
  logic                  q0_valid, q1_valid;

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_addr <= init_addr + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (init_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) state_nxt = ST_READY;
      end
      default: state_nxt = ST_READY;
    endcase
  end

  assign wr_en  = !init_busy && !csb0 && !web0;
  assign rd0_en = !init_busy && !csb0 && web0;
  assign rd1_en = !init_busy && !csb1;
  assign hit    = wr_en && (addr1 == addr0);

  // Array has no reset; the rst guard only keeps the clear counter from writing while held.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      if (init_busy) begin
        mem[init_addr] <= '0;
      end else if (wr_en) begin
        for (int l = 0; l < NUM_WMASKS; l++)
          if (wmask0[l]) mem[addr0][l*LANE_WIDTH +: LANE_WIDTH] <= din0[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Write-first bypass: lanes being written this cycle come straight from din0.
  always_comb begin
    rd1_word = mem[addr1];
    for (int l = 0; l < NUM_WMASKS; l++)
      if (hit && wmask0[l]) rd1_word[l*LANE_WIDTH +: LANE_WIDTH] = din0[l*LANE_WIDTH +: LANE_WIDTH];
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      q0        <= '0;
      q0_valid  <= 1'b0;
      q1        <= '0;
      q1_valid  <= 1'b0;
      collision <= 1'b0;
    end else begin
      q0_valid  <= rd0_en;
      q1_valid  <= rd1_en;
      collision <= rd1_en && hit;
      if (rd0_en) q0 <= mem[addr0];
      if (rd1_en) q1 <= rd1_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      sram_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out0 (
        .clk0(clk0), .rst(rst), .din(q0), .vin(q0_valid), .dout(dout0), .vout(dout0_valid)
      );
      sram_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out1 (
        .clk0(clk0), .rst(rst), .din(q1), .vin(q1_valid), .dout(dout1), .vout(dout1_valid)
      );
    end else begin : g_no_out_reg
      assign dout0       = q0;
      assign dout0_valid = q0_valid;
      assign dout1       = q1;
      assign dout1_valid = q1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: one instance without and one with the output stage,
// driven identically and compared every cycle against a word-level memory model.
module tb_sram_1rw1r_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic        a_v0, a_v1, b_v0, b_v1, a_busy, b_busy, a_col, b_col;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LANE_WIDTH(8), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk0(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(a_dout0), .dout0_valid(a_v0), .csb1(csb1), .addr1(addr1), .dout1(a_dout1),
    .dout1_valid(a_v1), .init_busy(a_busy), .collision(a_col)
  );

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LANE_WIDTH(8), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk0(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(b_dout0), .dout0_valid(b_v0), .csb1(csb1), .addr1(addr1), .dout1(b_dout1),
    .dout1_valid(b_v1), .init_busy(b_busy), .collision(b_col)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: memory array, remaining clear cycles, and delay lines of expected read results.
  logic [31:0] m_mem [256];
  int          m_busy = 0;
  bit          model_ok = 1'b0;
  logic [31:0] m1_d0 = '0, m1_d1 = '0, m2_d0 = '0, m2_d1 = '0;
  logic        m1_v0 = 1'b0, m1_v1 = 1'b0, m2_v0 = 1'b0, m2_v1 = 1'b0, m_col = 1'b0;

  initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 256;
      m1_d0 = '0; m1_d1 = '0; m2_d0 = '0; m2_d1 = '0;
      m1_v0 = 1'b0; m1_v1 = 1'b0; m2_v0 = 1'b0; m2_v1 = 1'b0; m_col = 1'b0;
      model_ok = 1'b1;
    end else begin
      logic [31:0] w0, w1;
      bit          r0, r1, wr;
      m2_v0 = m1_v0; if (m1_v0) m2_d0 = m1_d0;
      m2_v1 = m1_v1; if (m1_v1) m2_d1 = m1_d1;
      if (m_busy > 0) begin
        m_mem[256 - m_busy] = '0;
        m_busy--;
        r0 = 1'b0; r1 = 1'b0; wr = 1'b0;
      end else begin
        r0 = !csb0 && web0;
        r1 = !csb1;
        wr = !csb0 && !web0;
      end
      w0 = m_mem[addr0];
      w1 = m_mem[addr1];
      if (wr) begin
        for (int l = 0; l < 4; l++)
          if (wmask0[l]) m_mem[addr0][l*8 +: 8] = din0[l*8 +: 8];
        if (addr1 == addr0) w1 = m_mem[addr1];
      end
      m1_v0 = r0; if (r0) m1_d0 = w0;
      m1_v1 = r1; if (r1) m1_d1 = w1;
      m_col = r1 && wr && (addr1 == addr0);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmp_a_dout0", a_dout0, m1_d0);
      chk("cmp_a_v0", 32'(a_v0), 32'(m1_v0));
      chk("cmp_a_dout1", a_dout1, m1_d1);
      chk("cmp_a_v1", 32'(a_v1), 32'(m1_v1));
      chk("cmp_a_col", 32'(a_col), 32'(m_col));
      chk("cmp_a_busy", 32'(a_busy), 32'(m_busy > 0));
      chk("cmp_b_dout0", b_dout0, m2_d0);
      chk("cmp_b_v0", 32'(b_v0), 32'(m2_v0));
      chk("cmp_b_dout1", b_dout1, m2_d1);
      chk("cmp_b_v1", 32'(b_v1), 32'(m2_v1));
      chk("cmp_b_col", 32'(b_col), 32'(m_col));
      chk("cmp_b_busy", 32'(b_busy), 32'(m_busy > 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    step();
    idle();
  endtask

  task automatic rd0_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    step();
    idle();
    chk(name, a_dout0, exp);
    chk({name, "_valid"}, 32'(a_v0), 32'd1);
  endtask

  task automatic rd1_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    csb1 = 1'b0; addr1 = a;
    step();
    idle();
    chk(name, a_dout1, exp);
    chk({name, "_valid"}, 32'(a_v1), 32'd1);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (a_busy && n < 400) begin
      n++;
      step();
    end
    chk(name, n, 32'd256);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(a_busy), 32'd1);
    rst = 1'b0;
    count_busy("init_len");

    rd0_chk("rd_ff_p0", 8'hff, 32'h0);
    rd1_chk("rd_ff_p1", 8'hff, 32'h0);
    wr(8'hff, 32'h0BADF00D, 4'b1111);
    rd1_chk("rd_ff_written", 8'hff, 32'h0BADF00D);

    wr(8'h10, 32'hDEADBEEF, 4'b1111);
    rd0_chk("full_write", 8'h10, 32'hDEADBEEF);
    wr(8'h10, 32'h11223344, 4'b0101);
    rd0_chk("lane_write", 8'h10, 32'hDE22BE44);
    wr(8'h10, 32'hFFFFFFFF, 4'b0000);
    rd0_chk("mask_zero_write", 8'h10, 32'hDE22BE44);

    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'hCAFEF00D; wmask0 = 4'b1100;
    csb1 = 1'b0; addr1 = 8'h20;
    step();
    idle();
    chk("coll_data", a_dout1, 32'hCAFE0000);
    chk("coll_flag", 32'(a_col), 32'd1);
    step();
    chk("coll_pulse_end", 32'(a_col), 32'd0);

    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h21; din0 = 32'h12345678; wmask0 = 4'b1111;
    csb1 = 1'b0; addr1 = 8'h10;
    step();
    idle();
    chk("nocoll_data", a_dout1, 32'hDE22BE44);
    chk("nocoll_flag", 32'(a_col), 32'd0);
    rd1_chk("post_coll_word", 8'h20, 32'hCAFE0000);

    wr(8'h01, 32'hA, 4'b1111);
    wr(8'h02, 32'hB, 4'b1111);
    wr(8'h03, 32'hC, 4'b1111);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h01;
    step();
    chk("oreg_latency", 32'(b_v0), 32'd0);
    addr0 = 8'h02;
    step();
    chk("oreg_rd1", b_dout0, 32'hA);
    chk("oreg_rd1_valid", 32'(b_v0), 32'd1);
    addr0 = 8'h03;
    step();
    chk("oreg_rd2", b_dout0, 32'hB);
    chk("oreg_rd2_valid", 32'(b_v0), 32'd1);
    idle();
    step();
    chk("oreg_rd3", b_dout0, 32'hC);
    chk("oreg_rd3_valid", 32'(b_v0), 32'd1);
    step();
    chk("oreg_hold", b_dout0, 32'hC);
    chk("oreg_idle_valid", 32'(b_v0), 32'd0);

    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h03;
    step();
    chk("pre_rst_dout0", a_dout0, 32'hC);
    rst = 1'b1;
    #1;
    chk("rst_a_dout0", a_dout0, 32'h0);
    chk("rst_b_dout0", b_dout0, 32'h0);
    chk("rst_a_dout1", a_dout1, 32'h0);
    chk("rst_b_v0", 32'(b_v0), 32'd0);
    idle();
    step();
    rst = 1'b0;
    repeat (100) step();
    chk("init_mid_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_init_busy", 32'(a_busy), 32'd1);
    step();
    rst = 1'b0;
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h05; din0 = 32'h55555555; wmask0 = 4'b1111;
    csb1 = 1'b0; addr1 = 8'h05;
    count_busy("init_restart_len");
    idle();
    rd0_chk("cleared_3", 8'h03, 32'h0);
    rd1_chk("ignored_write_5", 8'h05, 32'h0);
    rd0_chk("cleared_ff", 8'hff, 32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
